// File: rtl/spi_target_regfile.sv
// rtl/spi_target_regfile.sv - SPI target terminating addr/data frames into a local register file
module spi_target_regfile #(
    parameter int NUM_REGS = 8
) (
    input  logic       pclk_i,
    input  logic       prst_i,
    input  logic       sclk_i,
    input  logic       cs_n_i,
    input  logic       mosi_i,
    output logic       miso_o,
    input  logic       lwr_en_i,
    input  logic [6:0] lwr_addr_i,
    input  logic [7:0] lwr_data_i,
    output logic       wr_valid_o,
    output logic       rd_valid_o,
    output logic [6:0] acc_addr_o,
    output logic [7:0] wr_data_o,
    output logic       err_o
);

    localparam int         AW         = $clog2(NUM_REGS);
    localparam logic [7:0] NUM_REGS_W = 8'(NUM_REGS);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    logic       sclk_s1, sclk_s2, sclk_h;
    logic       cs_n_s1, cs_n_s2;
    logic       mosi_s1, mosi_s2, mosi_h;
    logic       sclk_fall;

    logic [1:0] state;
    logic [2:0] bit_cnt;
    logic [2:0] bit_nxt;
    logic [6:0] addr_sr;
    logic [6:0] data_sr;
    logic [6:0] reg_addr;
    logic       wr_flag;
    logic [7:0] tx_sr;
    logic [7:0] regs [NUM_REGS];

    logic       lwr_in_range;
    logic       addr_in_range;
    logic       reg_in_range;
    logic [7:0] rd_byte;

    // Chip select needs no history flop: only its synced level is used.
    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            sclk_s1 <= 1'b1;
            sclk_s2 <= 1'b1;
            sclk_h  <= 1'b1;
            cs_n_s1 <= 1'b1;
            cs_n_s2 <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
            mosi_h  <= 1'b0;
        end else begin
            sclk_s1 <= sclk_i;
            sclk_s2 <= sclk_s1;
            sclk_h  <= sclk_s2;
            cs_n_s1 <= cs_n_i;
            cs_n_s2 <= cs_n_s1;
            mosi_s1 <= mosi_i;
            mosi_s2 <= mosi_s1;
            mosi_h  <= mosi_s2;
        end
    end

    // mosi_h is captured alongside sclk_h, i.e. the data level just before the falling edge.
    assign sclk_fall     = ~sclk_s2 & sclk_h;
    assign bit_nxt       = bit_cnt + 3'd1;
    assign lwr_in_range  = ({1'b0, lwr_addr_i} < NUM_REGS_W);
    assign addr_in_range = ({1'b0, addr_sr} < NUM_REGS_W);
    assign reg_in_range  = ({1'b0, reg_addr} < NUM_REGS_W);

    always_comb begin
        rd_byte = 8'h00;
        if (addr_in_range) begin
            rd_byte = regs[addr_sr[AW-1:0]];
        end
    end

    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            state      <= ST_IDLE;
            bit_cnt    <= 3'd0;
            addr_sr    <= 7'd0;
            data_sr    <= 7'd0;
            reg_addr   <= 7'd0;
            wr_flag    <= 1'b0;
            tx_sr      <= 8'h00;
            miso_o     <= 1'b1;
            wr_valid_o <= 1'b0;
            rd_valid_o <= 1'b0;
            err_o      <= 1'b0;
            acc_addr_o <= 7'd0;
            wr_data_o  <= 8'h00;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= 8'h00;
            end
        end else begin
            wr_valid_o <= 1'b0;
            rd_valid_o <= 1'b0;
            err_o      <= 1'b0;

            // Placed before the SPI commit so an SPI write to the same register wins.
            if (lwr_en_i && lwr_in_range) begin
                regs[lwr_addr_i[AW-1:0]] <= lwr_data_i;
            end

            if (cs_n_s2) begin
                state   <= ST_IDLE;
                bit_cnt <= 3'd0;
                miso_o  <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_ADDR;
                        if (sclk_fall) begin
                            addr_sr[0] <= mosi_h;
                            bit_cnt    <= 3'd1;
                        end
                    end
                    ST_ADDR: begin
                        if (sclk_fall) begin
                            bit_cnt <= bit_nxt;
                            if (bit_cnt == 3'd7) begin
                                state    <= ST_DATA;
                                wr_flag  <= mosi_h;
                                reg_addr <= addr_sr;
                                tx_sr    <= rd_byte;
                                miso_o   <= mosi_h ? 1'b1 : rd_byte[0];
                            end else begin
                                addr_sr[bit_cnt] <= mosi_h;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (sclk_fall) begin
                            bit_cnt <= bit_nxt;
                            if (bit_cnt == 3'd7) begin
                                state      <= ST_ADDR;
                                miso_o     <= 1'b1;
                                acc_addr_o <= reg_addr;
                                if (!reg_in_range) begin
                                    err_o <= 1'b1;
                                end else if (wr_flag) begin
                                    regs[reg_addr[AW-1:0]] <= {mosi_h, data_sr};
                                    wr_data_o              <= {mosi_h, data_sr};
                                    wr_valid_o             <= 1'b1;
                                end else begin
                                    rd_valid_o <= 1'b1;
                                end
                            end else begin
                                data_sr[bit_cnt] <= mosi_h;
                                if (!wr_flag) begin
                                    miso_o <= tx_sr[bit_nxt];
                                end
                            end
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        bit_cnt <= 3'd0;
                        miso_o  <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
